program_loader: RTL and testbench

//  Synthesizable host-side loader/monitor for Processor's external memory port. Consumes a

---
 rtl/program_loader.sv | 236 +++++++++++++++++++++++
 tb/tb_program_loader.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: byte-stream host loader/monitor that owns the processor's external memory port.
package program_loader_pkg;

    localparam logic [2:0] MEM_MODE_NONE = 3'd0;
    localparam logic [2:0] MEM_MODE_WORD = 3'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_LOAD_COLLECT,
        S_LOAD_WRITE,
        S_DUMP_READ,
        S_DUMP_CAP,
        S_DUMP_SEND,
        S_RUN,
        S_ACK,
        S_NAK
    } state_e;

endpackage

module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter bit          BIG_ENDIAN  = 1'b1,
    parameter int unsigned MEM_LATENCY = 1,
    parameter logic [7:0]  ACK_BYTE    = 8'h06,
    parameter logic [7:0]  NAK_BYTE    = 8'h15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rxData,
    input  logic                  rxValid,
    output logic                  rxReady,
    output logic [7:0]            txData,
    output logic                  txValid,
    input  logic                  txReady,
    output logic                  pause,
    output logic                  externalMemoryControl,
    output logic [ADDR_WIDTH-1:0] externalAddress,
    output logic [31:0]           externalData,
    output logic [2:0]            externalReadMode,
    output logic [2:0]            externalWriteMode,
    input  logic [31:0]           externalDataOut,
    output logic                  busy
);

    localparam int unsigned LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [7:0]  OP_LOAD = 8'h4C;
    localparam logic [7:0]  OP_DUMP = 8'h52;
    localparam logic [7:0]  OP_RUN  = 8'h47;

    state_e                  state_q, state_d;
    logic [7:0]              op_q, op_d;
    logic [2:0]              hdr_idx_q, hdr_idx_d;
    logic [31:0]             hdr_addr_q, hdr_addr_d;
    logic [31:0]             cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             word_q, word_d;
    logic [1:0]              byte_idx_q, byte_idx_d;
    logic [LAT_W-1:0]        lat_q, lat_d;
    logic                    rx_ready_q, rx_ready_d;
    logic                    tx_valid_q, tx_valid_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    pause_q, pause_d;
    logic                    busy_q, busy_d;
    logic [2:0]              rd_mode_q, rd_mode_d;
    logic [2:0]              wr_mode_q, wr_mode_d;
    logic                    rx_fire_c, tx_fire_c;

    // Shift one received byte into a word so the first byte lands in the configured lane.
    function automatic logic [31:0] shift_in(input logic [31:0] cur, input logic [7:0] b);
        if (BIG_ENDIAN) return {cur[23:0], b};
        return {b, cur[31:8]};
    endfunction

    // Pick the idx-th transmitted byte of a word in stream order.
    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        logic [1:0] lane;
        lane = BIG_ENDIAN ? ~idx : idx;
        return 8'(w >> {lane, 3'b000});
    endfunction

    assign rx_fire_c = rxValid & rx_ready_q;
    assign tx_fire_c = tx_valid_q & txReady;

    assign rxReady               = rx_ready_q;
    assign txValid               = tx_valid_q;
    assign txData                = tx_data_q;
    assign pause                 = pause_q;
    assign externalMemoryControl = pause_q;
    assign externalAddress       = addr_q;
    assign externalData          = word_q;
    assign externalReadMode      = rd_mode_q;
    assign externalWriteMode     = wr_mode_q;
    assign busy                  = busy_q;

    // Command sequencing; outputs are decoded from the next state so they register with it.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        hdr_idx_d  = hdr_idx_q;
        hdr_addr_d = hdr_addr_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        lat_d      = lat_q;
        tx_data_d  = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (rx_fire_c) begin
                    if (rxData == OP_LOAD || rxData == OP_DUMP || rxData == OP_RUN) begin
                        op_d      = rxData;
                        hdr_idx_d = 3'd0;
                        state_d   = S_HDR;
                    end else begin
                        state_d = S_NAK;
                    end
                end
            end
            S_HDR: begin
                if (rx_fire_c) begin
                    hdr_idx_d = hdr_idx_q + 3'd1;
                    if (hdr_idx_q < 3'd4) hdr_addr_d = shift_in(hdr_addr_q, rxData);
                    else                  cnt_d      = shift_in(cnt_q, rxData);
                    if (hdr_idx_q == 3'd7) begin
                        addr_d     = ADDR_WIDTH'(hdr_addr_q & 32'hFFFF_FFFC);
                        byte_idx_d = 2'd0;
                        lat_d      = '0;
                        if (cnt_d == 32'd0)      state_d = S_ACK;
                        else if (op_q == OP_LOAD) state_d = S_LOAD_COLLECT;
                        else if (op_q == OP_DUMP) state_d = S_DUMP_READ;
                        else                      state_d = S_RUN;
                    end
                end
            end
            S_LOAD_COLLECT: begin
                if (rx_fire_c) begin
                    word_d     = shift_in(word_q, rxData);
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) state_d = S_LOAD_WRITE;
                end
            end
            S_LOAD_WRITE: begin
                addr_d  = addr_q + ADDR_WIDTH'(4);
                cnt_d   = cnt_q - 32'd1;
                state_d = (cnt_q == 32'd1) ? S_ACK : S_LOAD_COLLECT;
            end
            S_DUMP_READ: begin
                lat_d = lat_q + LAT_W'(1);
                if (lat_q == LAT_W'(MEM_LATENCY - 1)) state_d = S_DUMP_CAP;
            end
            S_DUMP_CAP: begin
                word_d     = externalDataOut;
                byte_idx_d = 2'd0;
                state_d    = S_DUMP_SEND;
            end
            S_DUMP_SEND: begin
                if (tx_fire_c) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        addr_d  = addr_q + ADDR_WIDTH'(4);
                        cnt_d   = cnt_q - 32'd1;
                        lat_d   = '0;
                        state_d = (cnt_q == 32'd1) ? S_ACK : S_DUMP_READ;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 32'd1;
                if (cnt_q == 32'd1) state_d = S_ACK;
            end
            S_ACK, S_NAK: begin
                if (tx_fire_c) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        rx_ready_d = (state_d == S_IDLE) || (state_d == S_HDR) || (state_d == S_LOAD_COLLECT);
        tx_valid_d = (state_d == S_ACK) || (state_d == S_NAK) || (state_d == S_DUMP_SEND);
        pause_d    = (state_d != S_RUN);
        busy_d     = (state_d != S_IDLE);
        rd_mode_d  = (state_d == S_DUMP_READ)  ? MEM_MODE_WORD : MEM_MODE_NONE;
        wr_mode_d  = (state_d == S_LOAD_WRITE) ? MEM_MODE_WORD : MEM_MODE_NONE;

        case (state_d)
            S_ACK:       tx_data_d = ACK_BYTE;
            S_NAK:       tx_data_d = NAK_BYTE;
            S_DUMP_SEND: tx_data_d = byte_sel(word_d, byte_idx_d);
            default:     tx_data_d = 8'h00;
        endcase
    end

    // State and registered outputs; reset re-pauses the core and drops any partial command.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            op_q       <= 8'h00;
            hdr_idx_q  <= 3'd0;
            hdr_addr_q <= 32'd0;
            cnt_q      <= 32'd0;
            addr_q     <= '0;
            word_q     <= 32'd0;
            byte_idx_q <= 2'd0;
            lat_q      <= '0;
            rx_ready_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            pause_q    <= 1'b1;
            busy_q     <= 1'b0;
            rd_mode_q  <= MEM_MODE_NONE;
            wr_mode_q  <= MEM_MODE_NONE;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            hdr_idx_q  <= hdr_idx_d;
            hdr_addr_q <= hdr_addr_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            lat_q      <= lat_d;
            rx_ready_q <= rx_ready_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            pause_q    <= pause_d;
            busy_q     <= busy_d;
            rd_mode_q  <= rd_mode_d;
            wr_mode_q  <= wr_mode_d;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: command table plus stall/reset corner sequences.
module tb_program_loader;

    localparam logic [2:0] M_NONE = 3'd0;
    localparam logic [2:0] M_WORD = 3'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        rxReady;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;
    logic        pause;
    logic        externalMemoryControl;
    logic [31:0] externalAddress;
    logic [31:0] externalData;
    logic [2:0]  externalReadMode;
    logic [2:0]  externalWriteMode;
    logic [31:0] externalDataOut = 32'd0;
    logic        busy;

    program_loader dut (
        .clk                   (clk),
        .rst                   (rst),
        .rxData                (rxData),
        .rxValid               (rxValid),
        .rxReady               (rxReady),
        .txData                (txData),
        .txValid               (txValid),
        .txReady               (txReady),
        .pause                 (pause),
        .externalMemoryControl (externalMemoryControl),
        .externalAddress       (externalAddress),
        .externalData          (externalData),
        .externalReadMode      (externalReadMode),
        .externalWriteMode     (externalWriteMode),
        .externalDataOut       (externalDataOut),
        .busy                  (busy)
    );

    always #5 clk = ~clk;

    // Word memory with one cycle read latency.
    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (externalWriteMode == M_WORD) mem[externalAddress[11:2]] <= externalData;
        if (externalReadMode == M_WORD)  externalDataOut <= mem[externalAddress[11:2]];
    end

    // Observers sampled on the falling edge: tx bytes, write log, run cycles, protocol rules.
    logic [7:0]  txq [$];
    logic [31:0] wr_a [$];
    logic [31:0] wr_d [$];
    int          run_cycles = 0;
    int          viol = 0;
    logic        stall_prev = 1'b0;
    logic [7:0]  data_prev = 8'h00;
    always @(negedge clk) begin
        if (txValid && txReady) txq.push_back(txData);
        if (externalWriteMode == M_WORD) begin
            wr_a.push_back(externalAddress);
            wr_d.push_back(externalData);
        end
        if (!pause) run_cycles++;
        if (externalReadMode == M_WORD && externalWriteMode == M_WORD) viol++;
        if (pause != externalMemoryControl) viol++;
        if (!externalMemoryControl && (externalReadMode != M_NONE || externalWriteMode != M_NONE)) viol++;
        if (rst && stall_prev && (!txValid || txData != data_prev)) viol++;
        stall_prev = rst && txValid && !txReady;
        data_prev  = txData;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        rxData  = b;
        rxValid = 1'b1;
        while (!rxReady && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (!rxReady) begin
            $display("FAIL rx_accept_timeout: got rxReady=0 expected 1 for byte %h", b);
            $fatal(1);
        end
        @(posedge clk); #1;
        rxValid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8]);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] addr,
                              input logic [31:0] cnt, input logic [63:0] pay);
        send_byte(op);
        if (op == 8'h4C || op == 8'h52 || op == 8'h47) begin
            send_word(addr);
            send_word(cnt);
            if (op == 8'h4C)
                for (int w = 0; w < int'(cnt) && w < 2; w++) send_word(pay[63-32*w -: 32]);
        end
    endtask

    task automatic wait_rsp(input int base, input int n, input string name);
        int t;
        t = 0;
        while (txq.size() < base + n && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        if (txq.size() < base + n) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d bytes expected %0d", name, txq.size() - base, n);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] cnt;
        logic [63:0] pay;
        logic [95:0] rsp;
        int          nrsp;
        int          nwr;
        logic [31:0] wa0;
        logic [31:0] wd0;
        logic [31:0] wa1;
        logic [31:0] wd1;
        int          run;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    initial begin
        int base;
        int wbase;
        int rbase;

        vecs[0]  = '{8'h4C, 32'h0000_0400, 32'd2,  64'h0800FFFB_00000000, {8'h06, 88'h0}, 1, 2,
                     32'h400, 32'h0800FFFB, 32'h404, 32'h0, 0};
        vecs[1]  = '{8'h52, 32'h0000_0400, 32'd2,  64'h0, {64'h0800FFFB_00000000, 8'h06, 24'h0}, 9, 0,
                     32'h0, 32'h0, 32'h0, 32'h0, 0};
        vecs[2]  = '{8'h58, 32'h0, 32'd0, 64'h0, {8'h15, 88'h0}, 1, 0,
                     32'h0, 32'h0, 32'h0, 32'h0, 0};
        vecs[3]  = '{8'h4C, 32'h0000_0402, 32'd0,  64'h0, {8'h06, 88'h0}, 1, 0,
                     32'h0, 32'h0, 32'h0, 32'h0, 0};
        vecs[4]  = '{8'h4C, 32'h0000_0403, 32'd1,  64'hDEADBEEF_00000000, {8'h06, 88'h0}, 1, 1,
                     32'h400, 32'hDEADBEEF, 32'h0, 32'h0, 0};
        vecs[5]  = '{8'h52, 32'h0000_0401, 32'd1,  64'h0, {32'hDEADBEEF, 8'h06, 56'h0}, 5, 0,
                     32'h0, 32'h0, 32'h0, 32'h0, 0};
        vecs[6]  = '{8'h52, 32'h0000_0404, 32'd0,  64'h0, {8'h06, 88'h0}, 1, 0,
                     32'h0, 32'h0, 32'h0, 32'h0, 0};
        vecs[7]  = '{8'h47, 32'h0, 32'd0,  64'h0, {8'h06, 88'h0}, 1, 0,
                     32'h0, 32'h0, 32'h0, 32'h0, 0};
        vecs[8]  = '{8'h47, 32'h0, 32'd10, 64'h0, {8'h06, 88'h0}, 1, 0,
                     32'h0, 32'h0, 32'h0, 32'h0, 10};
        vecs[9]  = '{8'h4C, 32'hFFFF_FFFC, 32'd2, 64'h11223344_55667788, {8'h06, 88'h0}, 1, 2,
                     32'hFFFF_FFFC, 32'h11223344, 32'h0, 32'h55667788, 0};
        vecs[10] = '{8'h52, 32'hFFFF_FFFC, 32'd2, 64'h0, {64'h11223344_55667788, 8'h06, 24'h0}, 9, 0,
                     32'h0, 32'h0, 32'h0, 32'h0, 0};

        rst     = 1'b0;
        rxValid = 1'b0;
        rxData  = 8'h00;
        txReady = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_pause",   32'(pause), 32'd1);
        check("rst_extctl",  32'(externalMemoryControl), 32'd1);
        check("rst_rdmode",  32'(externalReadMode), 32'(M_NONE));
        check("rst_wrmode",  32'(externalWriteMode), 32'(M_NONE));
        check("rst_addr",    externalAddress, 32'h0);
        check("rst_data",    externalData, 32'h0);
        check("rst_rxready", 32'(rxReady), 32'd0);
        check("rst_txvalid", 32'(txValid), 32'd0);
        check("rst_busy",    32'(busy), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle_rxready", 32'(rxReady), 32'd1);
        check("idle_busy",    32'(busy), 32'd0);

        // Table of complete commands.
        for (int vi = 0; vi < NV; vi++) begin
            base  = txq.size();
            wbase = wr_a.size();
            rbase = run_cycles;
            send_frame(vecs[vi].op, vecs[vi].addr, vecs[vi].cnt, vecs[vi].pay);
            wait_rsp(base, vecs[vi].nrsp, $sformatf("v%0d", vi));
            check($sformatf("v%0d_nbytes", vi), 32'(txq.size() - base), 32'(vecs[vi].nrsp));
            for (int i = 0; i < vecs[vi].nrsp && base + i < txq.size(); i++)
                check($sformatf("v%0d_byte%0d", vi, i), 32'(txq[base+i]), 32'(vecs[vi].rsp[95-8*i -: 8]));
            check($sformatf("v%0d_nwrites", vi), 32'(wr_a.size() - wbase), 32'(vecs[vi].nwr));
            if (vecs[vi].nwr > 0 && wr_a.size() > wbase) begin
                check($sformatf("v%0d_wa0", vi), wr_a[wbase], vecs[vi].wa0);
                check($sformatf("v%0d_wd0", vi), wr_d[wbase], vecs[vi].wd0);
            end
            if (vecs[vi].nwr > 1 && wr_a.size() > wbase + 1) begin
                check($sformatf("v%0d_wa1", vi), wr_a[wbase+1], vecs[vi].wa1);
                check($sformatf("v%0d_wd1", vi), wr_d[wbase+1], vecs[vi].wd1);
            end
            check($sformatf("v%0d_run_cycles", vi), 32'(run_cycles - rbase), 32'(vecs[vi].run));
            check($sformatf("v%0d_busy_end", vi), 32'(busy), 32'd0);
            check($sformatf("v%0d_pause_end", vi), 32'(pause), 32'd1);
        end

        // Dump with the sink stalled for 20 cycles.
        base    = txq.size();
        txReady = 1'b0;
        send_frame(8'h52, 32'h400, 32'd2, 64'h0);
        repeat (20) @(posedge clk);
        #1;
        check("stall_nbytes",  32'(txq.size() - base), 32'd0);
        check("stall_txvalid", 32'(txValid), 32'd1);
        check("stall_txdata",  32'(txData), 32'hDE);
        txReady = 1'b1;
        wait_rsp(base, 9, "stall");
        check("stall_total", 32'(txq.size() - base), 32'd9);
        begin
            logic [71:0] exp_s;
            exp_s = 72'hDEADBEEF_00000000_06;
            for (int i = 0; i < 9 && base + i < txq.size(); i++)
                check($sformatf("stall_byte%0d", i), 32'(txq[base+i]), 32'(exp_s[71-8*i -: 8]));
        end

        // Byte offered while a NAK is pending stays upstream until IDLE.
        base    = txq.size();
        txReady = 1'b0;
        send_byte(8'h58);
        rxData  = 8'h58;
        rxValid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("nak_hold_rxready", 32'(rxReady), 32'd0);
        check("nak_hold_busy",    32'(busy), 32'd1);
        txReady = 1'b1;
        send_byte(8'h58);
        wait_rsp(base, 2, "nak_pair");
        check("nak_pair_n", 32'(txq.size() - base), 32'd2);
        if (txq.size() >= base + 2) begin
            check("nak_pair_0", 32'(txq[base]),   32'h15);
            check("nak_pair_1", 32'(txq[base+1]), 32'h15);
        end

        // Reset in the middle of a load payload, then a clean load.
        base = txq.size();
        send_byte(8'h4C);
        send_word(32'h400);
        send_word(32'd1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        wbase = wr_a.size();
        rst = 1'b0;
        #1;
        check("mrst_pause",   32'(pause), 32'd1);
        check("mrst_extctl",  32'(externalMemoryControl), 32'd1);
        check("mrst_busy",    32'(busy), 32'd0);
        check("mrst_rxready", 32'(rxReady), 32'd0);
        check("mrst_wrmode",  32'(externalWriteMode), 32'(M_NONE));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        send_frame(8'h4C, 32'h500, 32'd1, 64'hCAFEF00D_00000000);
        wait_rsp(base, 1, "mrst_load");
        check("mrst_nbytes", 32'(txq.size() - base), 32'd1);
        if (txq.size() > base) check("mrst_ack", 32'(txq[base]), 32'h06);
        check("mrst_nwrites", 32'(wr_a.size() - wbase), 32'd1);
        if (wr_a.size() > wbase) begin
            check("mrst_wa", wr_a[wbase], 32'h500);
            check("mrst_wd", wr_d[wbase], 32'hCAFEF00D);
        end

        // Reset while the core is running: re-paused at once, no ACK.
        base = txq.size();
        send_frame(8'h47, 32'h0, 32'd50, 64'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rrst_running_pause",  32'(pause), 32'd0);
        check("rrst_running_extctl", 32'(externalMemoryControl), 32'd0);
        rst = 1'b0;
        #1;
        check("rrst_pause",  32'(pause), 32'd1);
        check("rrst_extctl", 32'(externalMemoryControl), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check("rrst_no_ack", 32'(txq.size() - base), 32'd0);
        check("rrst_busy",   32'(busy), 32'd0);

        check("protocol_violations", 32'(viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Run-time bound.
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
